cv32e40p_instr_packer: RTL and testbench

//  Writer-side counterpart of the fetch aligner: accepts a stream of RVC/RV32 instructions (16 or 32 bit) and packs them into

---
 rtl/cv32e40p_instr_packer.sv | 152 +++++++++++++++
 tb/tb_cv32e40p_instr_packer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_packer.sv
// Packs a stream of 16/32-bit instructions into word-aligned 32-bit writes
// with byte enables; one emitted word per cycle at most.
module cv32e40p_instr_packer #(
  parameter logic [15:0] PAD_HALF = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] start_addr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic [31:0] word_addr_o,
  output logic [3:0]  word_be_o,
  output logic [31:0] instr_addr_o,
  output logic        idle_o
);

  localparam logic [1:0] S_ALIGNED    = 2'd0;
  localparam logic [1:0] S_HALF       = 2'd1;
  localparam logic [1:0] S_MISALIGNED = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [15:0] r_half;
  logic        r_word_valid;
  logic [31:0] r_word;
  logic [31:0] r_word_addr;
  logic [3:0]  r_be;

  logic        w_slot_free;
  logic        w_accept;
  logic        w_is32;
  logic        w_flush;
  logic [31:0] w_waddr;
  logic [31:0] w_len;

  logic        w_emit;
  logic [31:0] w_emit_word;
  logic [3:0]  w_emit_be;
  logic [31:0] w_next_addr;
  logic [1:0]  w_next_state;
  logic        w_half_ld;
  logic [15:0] w_next_half;

  assign w_slot_free   = !r_word_valid || word_ready_i;
  assign instr_ready_o = w_slot_free && !start_i && !flush_i && !rst;
  assign w_accept      = instr_valid_i && instr_ready_o;
  assign w_is32        = (instr_i[1:0] == 2'b11);
  assign w_len         = w_is32 ? 32'd4 : 32'd2;
  assign w_waddr       = {r_addr[31:2], 2'b00};
  assign w_flush       = !start_i && flush_i && w_slot_free
                         && (r_state == S_HALF);

  always_comb begin
    w_emit       = 1'b0;
    w_emit_word  = 32'h0;
    w_emit_be    = 4'h0;
    w_next_addr  = r_addr;
    w_next_state = r_state;
    w_half_ld    = 1'b0;
    w_next_half  = r_half;
    if (w_flush) begin
      w_emit       = 1'b1;
      w_emit_word  = {PAD_HALF, r_half};
      w_emit_be    = 4'b0011;
      w_next_state = S_MISALIGNED;
    end else if (w_accept) begin
      w_next_addr = r_addr + w_len;
      unique case (r_state)
        S_HALF: begin
          w_emit      = 1'b1;
          w_emit_word = {instr_i[15:0], r_half};
          w_emit_be   = 4'b1111;
          if (w_is32) begin
            w_half_ld   = 1'b1;
            w_next_half = instr_i[31:16];
          end else begin
            w_next_state = S_ALIGNED;
          end
        end
        S_MISALIGNED: begin
          w_emit      = 1'b1;
          w_emit_word = {instr_i[15:0], PAD_HALF};
          w_emit_be   = 4'b1100;
          if (w_is32) begin
            w_half_ld    = 1'b1;
            w_next_half  = instr_i[31:16];
            w_next_state = S_HALF;
          end else begin
            w_next_state = S_ALIGNED;
          end
        end
        default: begin
          if (w_is32) begin
            w_emit      = 1'b1;
            w_emit_word = instr_i;
            w_emit_be   = 4'b1111;
          end else begin
            w_half_ld    = 1'b1;
            w_next_half  = instr_i[15:0];
            w_next_state = S_HALF;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_ALIGNED;
      r_addr       <= 32'h0;
      r_half       <= 16'h0;
      r_word_valid <= 1'b0;
      r_word       <= 32'h0;
      r_word_addr  <= 32'h0;
      r_be         <= 4'h0;
    end else begin
      if (r_word_valid && word_ready_i)
        r_word_valid <= 1'b0;
      if (start_i) begin
        // A word already presented survives a restart until handshake.
        r_addr  <= start_addr_i & ~32'h1;
        r_state <= start_addr_i[1] ? S_MISALIGNED : S_ALIGNED;
        r_half  <= 16'h0;
      end else begin
        r_addr  <= w_next_addr;
        r_state <= w_next_state;
        if (w_half_ld)
          r_half <= w_next_half;
        if (w_emit) begin
          r_word_valid <= 1'b1;
          r_word       <= w_emit_word;
          r_word_addr  <= w_waddr;
          r_be         <= w_emit_be;
        end
      end
    end
  end

  assign word_valid_o = r_word_valid;
  assign word_o       = r_word;
  assign word_addr_o  = r_word_addr;
  assign word_be_o    = r_be;
  assign instr_addr_o = r_addr;
  assign idle_o       = (r_state != S_HALF) && !r_word_valid;

endmodule

// File: tb/tb_cv32e40p_instr_packer.sv
// Directed bench for cv32e40p_instr_packer with hand-computed expectations.
module tb_cv32e40p_instr_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] start_addr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic        flush_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_o;
  logic [31:0] word_addr_o;
  logic [3:0]  word_be_o;
  logic [31:0] instr_addr_o;
  logic        idle_o;

  int n_chk  = 0;
  int n_pass = 0;

  cv32e40p_instr_packer #(.PAD_HALF(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .start_addr_i  (start_addr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .flush_i       (flush_i),
    .word_valid_o  (word_valid_o),
    .word_ready_i  (word_ready_i),
    .word_o        (word_o),
    .word_addr_o   (word_addr_o),
    .word_be_o     (word_be_o),
    .instr_addr_o  (instr_addr_o),
    .idle_o        (idle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a);
    start_i      = 1'b1;
    start_addr_i = a;
    step();
    start_i = 1'b0;
  endtask

  task automatic send(input string tag, input logic [31:0] ins);
    instr_valid_i = 1'b1;
    instr_i       = ins;
    #1;
    chk({tag, "_rdy"}, {31'b0, instr_ready_o}, 32'd1);
    step();
    instr_valid_i = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w,
                          input logic [31:0] a, input logic [3:0] be);
    chk({tag, "_vld"},  {31'b0, word_valid_o}, 32'd1);
    chk({tag, "_word"}, word_o, w);
    chk({tag, "_addr"}, word_addr_o, a);
    chk({tag, "_be"},   {28'b0, word_be_o}, {28'b0, be});
  endtask

  initial begin
    rst           = 1'b1;
    start_i       = 1'b0;
    start_addr_i  = 32'h0;
    instr_valid_i = 1'b0;
    instr_i       = 32'h0;
    flush_i       = 1'b0;
    word_ready_i  = 1'b1;
    step();
    step();
    chk("rst_vld",   {31'b0, word_valid_o}, 32'd0);
    chk("rst_word",  word_o, 32'h0);
    chk("rst_waddr", word_addr_o, 32'h0);
    chk("rst_be",    {28'b0, word_be_o}, 32'h0);
    chk("rst_iaddr", instr_addr_o, 32'h0);
    chk("rst_rdy",   {31'b0, instr_ready_o}, 32'd0);
    chk("rst_idle",  {31'b0, idle_o}, 32'd1);
    rst = 1'b0;

    // Aligned 32-bit
    do_start(32'h100);
    chk("st_iaddr", instr_addr_o, 32'h100);
    send("a32", 32'h00A00093);
    chk_word("a32", 32'h00A00093, 32'h100, 4'hF);
    chk("a32_iaddr", instr_addr_o, 32'h104);
    step();
    chk("a32_drain", {31'b0, word_valid_o}, 32'd0);

    // Two 16-bit sharing a word
    do_start(32'h100);
    send("c0", 32'h00004501);
    chk("c0_vld",   {31'b0, word_valid_o}, 32'd0);
    chk("c0_idle",  {31'b0, idle_o}, 32'd0);
    chk("c0_iaddr", instr_addr_o, 32'h102);
    send("c1", 32'h00004585);
    chk_word("c1", 32'h45854501, 32'h100, 4'hF);
    chk("c1_iaddr", instr_addr_o, 32'h104);
    step();
    chk("c1_idle", {31'b0, idle_o}, 32'd1);

    // Misaligned 32-bit then flush
    do_start(32'h102);
    send("m32", 32'h12345677);
    chk_word("m32", 32'h56770000, 32'h100, 4'hC);
    chk("m32_iaddr", instr_addr_o, 32'h106);
    flush_i = 1'b1;
    #1;
    chk("fl_rdy", {31'b0, instr_ready_o}, 32'd0);
    step();
    flush_i = 1'b0;
    chk_word("fl", 32'h00001234, 32'h104, 4'h3);
    chk("fl_iaddr", instr_addr_o, 32'h106);
    step();
    chk("fl_idle", {31'b0, idle_o}, 32'd1);

    // Backpressure while HALF holds a half
    do_start(32'h202);
    word_ready_i = 1'b0;
    send("bp0", 32'h12345677);
    chk_word("bp0", 32'h56770000, 32'h200, 4'hC);
    instr_valid_i = 1'b1;
    instr_i       = 32'h00004501;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", {31'b0, instr_ready_o}, 32'd0);
      step();
      chk("bp_word", word_o, 32'h56770000);
      chk("bp_vld", {31'b0, word_valid_o}, 32'd1);
    end
    word_ready_i = 1'b1;
    #1;
    chk("bp_rel_rdy", {31'b0, instr_ready_o}, 32'd1);
    step();
    instr_valid_i = 1'b0;
    chk_word("bp1", 32'h45011234, 32'h204, 4'hF);
    chk("bp1_iaddr", instr_addr_o, 32'h208);
    step();

    // Address wrap
    do_start(32'hFFFFFFFC);
    send("wr0", 32'h00A00093);
    chk_word("wr0", 32'h00A00093, 32'hFFFFFFFC, 4'hF);
    send("wr1", 32'h00B00113);
    chk_word("wr1", 32'h00B00113, 32'h0, 4'hF);
    chk("wr_iaddr", instr_addr_o, 32'h4);
    step();

    // Start beats flush in HALF
    do_start(32'h300);
    send("sf0", 32'h00004501);
    start_i      = 1'b1;
    flush_i      = 1'b1;
    start_addr_i = 32'h400;
    step();
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("sf_vld",   {31'b0, word_valid_o}, 32'd0);
    chk("sf_idle",  {31'b0, idle_o}, 32'd1);
    chk("sf_iaddr", instr_addr_o, 32'h400);

    // Reset while HALF
    send("rh0", 32'h00004501);
    chk("rh_busy", {31'b0, idle_o}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh_idle",  {31'b0, idle_o}, 32'd1);
    chk("rh_vld",   {31'b0, word_valid_o}, 32'd0);
    chk("rh_iaddr", instr_addr_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
